axil_macc_accum: RTL and testbench
==================================

// Module: axil_macc_accum
// PURPOSE
//  Accumulation stage directly downstream of the 32x32 signed product multiplier in the axil_macc datapath.
//  Consumes a stream of signed products over a valid/ready handshake and sums exactly LEN of them.
//  Presents the final sum to the AXI-Lite result register with a valid/ready handshake.
//  Sustains one product per cycle; the control FSM sequences start/accumulate/deliver.
// PARAMETERS
//  DATA_W  32  product width; two's complement, sign-extended into the accumulator
//  ACC_W   32  accumulator/result width; must be >= DATA_W (elaboration error otherwise)
//  LEN_W   16  width of the product-count operand
// PORTS
//  ap_clk      in   1       single clock; all state on rising edge
//  ap_rst_n    in   1       asynchronous, active-low reset
//  start       in   1       one-cycle request to begin; honoured only in IDLE
//  len         in   LEN_W   number of products to sum; sampled when start is accepted
//  busy        out  1       high in ACC and DONE
//  prod_data   in   DATA_W  signed product from the multiplier
//  prod_valid  in   1       prod_data is valid
//  prod_ready  out  1       high only in ACC
//  acc_out     out  ACC_W   result; stable while acc_valid=1
//  acc_valid   out  1       result available (DONE)
//  acc_ready   in   1       consumer takes result
//  acc_ovf     out  1       sticky overflow flag for the current job (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; acc_out=0, acc_valid=0, prod_ready=0, busy=0, acc_ovf=0, count=0.
//  IDLE: start=1 -> latch len, clear acc, count and acc_ovf.
//    len!=0 -> ACC; len==0 -> DONE with acc_out=0.
//  ACC: prod_ready=1. A beat is prod_valid&prod_ready.
//    Each beat: acc <= acc + sext(prod_data) mod 2^ACC_W; count++.
//    The beat with count==len_q-1 moves to DONE.
//    No beat -> hold state and value.
//  DONE: acc_valid=1, prod_ready=0, and acc_out is unchanged.
//    acc_ready=1 -> IDLE next cycle; acc_out retains its value, acc_valid=0.
//  Latency: acc_valid rises the cycle after the last accepted beat. The minimum job of N products occupies N+2 cycles, start to IDLE.
//  Gaps in prod_valid stall accumulation without loss. Back-pressure on acc_ready holds DONE indefinitely.
//  start outside IDLE is ignored; len changes outside the start cycle are ignored.
//  start in the same cycle DONE->IDLE completes is ignored, because the FSM is not yet in IDLE.
//  count wraps never: len_q <= 2^LEN_W-1 and count stops at len_q-1.
//  ap_rst_n asserted mid-job aborts immediately to reset values; partial sum is lost.
// CONFIGURATION
//  AXIL_MACC_ACC_SAT_EN defined:
//    Signed add saturates to +2^(ACC_W-1)-1 / -2^(ACC_W-1).
//    acc_ovf sets on any saturating beat and stays set until the next accepted start.
//  Undefined:
//    Add wraps modulo 2^ACC_W, matching HLS int semantics.
//    acc_ovf is tied to 0.
// STRUCTURE
//  Package axil_macc_pkg:
//    FSM state typedef (IDLE, ACC, DONE)
//    default width constants DATA_W/ACC_W/LEN_W
//    saturation limit constants
//  Sub-module axil_macc_accum_add:
//    combinational sext + add
//    optional saturation and overflow detect under AXIL_MACC_ACC_SAT_EN
//  Top module holds the FSM, counter, len latch and output registers.
// TESTING
//  1 Reset, then len=4, products 3,-5,7,100 back-to-back -> acc_out=105, acc_valid 1 cycle after 4th beat, acc_ovf=0.
//  2 len=0 -> DONE next cycle with acc_out=0; no prod_ready pulse.
//  3 len=3, prod_valid gapped, acc_ready held low 5 cycles -> acc_out=sum, stable throughout; extra start pulses ignored.
//  4 len=2, products 0x7FFFFFFF,1.
//      Without SAT_EN -> 0x80000000, acc_ovf=0.
//      With SAT_EN -> 0x7FFFFFFF, acc_ovf=1; the next job clears acc_ovf.
//  5 Mid-job (2 of 8 beats) assert ap_rst_n=0 asynchronously -> all outputs 0 the same cycle; fresh len=1 job then correct.
//  6 Random len 1..64 and random products with random valid/ready, compared against a reference sum model.

Source files
------------

// File: rtl/axil_macc_pkg.sv
// rtl/axil_macc_pkg.sv - shared state type, default widths and saturation limits for the axil_macc accumulator
package axil_macc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_LEN_W  = 16;

  localparam logic [DEF_ACC_W-1:0] SAT_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
  localparam logic [DEF_ACC_W-1:0] SAT_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

endpackage

// File: rtl/axil_macc_accum_add.sv
// rtl/axil_macc_accum_add.sv - combinational sign-extend and add of one product into the running sum
// AXIL_MACC_ACC_SAT_EN selects a saturating add with overflow detect; otherwise the add wraps.
module axil_macc_accum_add
  import axil_macc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  logic [ACC_W-1:0] ext;

  assign ext = ACC_W'($signed(prod));

`ifdef AXIL_MACC_ACC_SAT_EN
  localparam logic [ACC_W-1:0] LIM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] LIM_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] full;

  assign full = {acc[ACC_W-1], acc} + {ext[ACC_W-1], ext};

  // The two top bits of the one-bit-wider sum disagree exactly when the signed add overflowed.
  always_comb begin
    sum = full[ACC_W-1:0];
    ovf = 1'b0;
    if (full[ACC_W] != full[ACC_W-1]) begin
      ovf = 1'b1;
      sum = full[ACC_W] ? LIM_MIN : LIM_MAX;
    end
  end
`else
  assign sum = acc + ext;
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/axil_macc_accum.sv
// rtl/axil_macc_accum.sv - sums exactly len signed products and hands the result over a valid/ready handshake
// Saturating accumulation is selected with AXIL_MACC_ACC_SAT_EN (see axil_macc_accum_add).
module axil_macc_accum
  import axil_macc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  input  logic [DATA_W-1:0] prod_data,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              acc_ovf
);

  generate
    if (ACC_W < DATA_W) begin : g_bad_width
      $error("axil_macc_accum: ACC_W must be >= DATA_W");
    end
  endgenerate

  state_t           state;
  state_t           state_nx;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] sum;
  logic             ovf_q;
  logic             add_ovf;
  logic             beat;
  logic             last_beat;

  axil_macc_accum_add #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_add (
    .acc (acc_q),
    .prod(prod_data),
    .sum (sum),
    .ovf (add_ovf)
  );

  assign beat      = prod_valid & prod_ready;
  // ACC is only entered with len_q >= 1, so len_q - 1 never underflows here.
  assign last_beat = beat & (count == (len_q - LEN_W'(1)));

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = (len == '0) ? ST_DONE : ST_ACC;
        end
      end
      ST_ACC: begin
        if (last_beat) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        if (acc_ready) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      len_q <= '0;
      count <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      len_q <= len;
      count <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (beat) begin
      count <= count + LEN_W'(1);
      acc_q <= sum;
      ovf_q <= ovf_q | add_ovf;
    end
  end

  assign busy       = (state != ST_IDLE);
  assign prod_ready = (state == ST_ACC);
  assign acc_valid  = (state == ST_DONE);
  assign acc_out    = acc_q;
  assign acc_ovf    = ovf_q;

endmodule

// File: tb/tb_axil_macc_accum.sv
// tb/tb_axil_macc_accum.sv - directed and randomised self-checking bench for axil_macc_accum
module tb_axil_macc_accum;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic        busy;
  logic [31:0] prod_data = '0;
  logic        prod_valid = 1'b0;
  logic        prod_ready;
  logic [31:0] acc_out;
  logic        acc_valid;
  logic        acc_ready = 1'b0;
  logic        acc_ovf;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] prod_mem [0:63];
  logic [31:0] exp_sum;
  logic        exp_ovf;

  always #5 ap_clk = ~ap_clk;

  axil_macc_accum dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .prod_data (prod_data),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .acc_out   (acc_out),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .acc_ovf   (acc_ovf)
  );

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: sum of prod_mem[0..n-1] in 64-bit, wrapped or clamped per beat.
  task automatic ref_calc(input int n, output logic [31:0] s, output logic o);
    longint acc;
    acc = 0;
    o = 1'b0;
    for (int i = 0; i < n; i++) begin
      acc = acc + longint'($signed(prod_mem[i]));
`ifdef AXIL_MACC_ACC_SAT_EN
      if (acc > 64'sd2147483647) begin
        acc = 64'sd2147483647;
        o = 1'b1;
      end else if (acc < -64'sd2147483648) begin
        acc = -64'sd2147483648;
        o = 1'b1;
      end
`endif
    end
    s = acc[31:0];
  endtask

  // Runs one job from IDLE; noisy=1 gaps prod_valid, wiggles len and pulses start while busy.
  task automatic run_job(input string tag, input int n, input bit noisy, input int rdelay,
                         input logic [31:0] es, input logic eo);
    int  i;
    int  cyc;
    bit  rdy;
    start = 1'b1;
    len   = 16'(n);
    tick();
    start = 1'b0;
    i = 0;
    cyc = 0;
    while (i < n && cyc < 2000) begin
      chk({tag, "_in_acc"}, {61'd0, busy, prod_ready, acc_valid}, 64'b110);
      prod_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
      prod_data  = prod_valid ? prod_mem[i] : $urandom;
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        len   = 16'($urandom);
      end
      rdy = prod_ready;
      tick();
      if (prod_valid && rdy) i++;
      cyc++;
    end
    if (i < n) chk({tag, "_beat_timeout"}, 64'(i), 64'(n));
    prod_valid = 1'b0;
    start = 1'b0;
    chk({tag, "_done"}, {61'd0, busy, prod_ready, acc_valid}, 64'b101);
    chk({tag, "_sum"}, {32'd0, acc_out}, {32'd0, es});
    chk({tag, "_ovf"}, {63'd0, acc_ovf}, {63'd0, eo});
    for (int k = 0; k < rdelay; k++) begin
      start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      prod_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    if (rdelay > 0) begin
      chk({tag, "_hold_valid"}, {63'd0, acc_valid}, 64'd1);
      chk({tag, "_hold_sum"}, {32'd0, acc_out}, {32'd0, es});
    end
    acc_ready  = 1'b1;
    start      = noisy;
    prod_valid = 1'b0;
    tick();
    acc_ready = 1'b0;
    start     = 1'b0;
    chk({tag, "_idle"}, {62'd0, busy, acc_valid}, 64'b00);
    chk({tag, "_retain"}, {32'd0, acc_out}, {32'd0, es});
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_outs", {60'd0, busy, prod_ready, acc_valid, acc_ovf}, 64'd0);
    chk("rst_acc", {32'd0, acc_out}, 64'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    tick();

    // 1: back-to-back 3,-5,7,100
    prod_mem[0] = 32'd3;
    prod_mem[1] = -32'sd5;
    prod_mem[2] = 32'd7;
    prod_mem[3] = 32'd100;
    run_job("t1", 4, 1'b0, 0, 32'd105, 1'b0);

    // 2: len=0 goes straight to DONE with zero
    run_job("t2", 0, 1'b0, 2, 32'd0, 1'b0);

    // 3: gapped valids, held result, stray starts
    prod_mem[0] = 32'd10;
    prod_mem[1] = -32'sd20;
    prod_mem[2] = 32'h1234;
    run_job("t3", 3, 1'b1, 5, 32'd4650, 1'b0);

    // 4: overflow at the positive limit, then a clean job clears acc_ovf
    prod_mem[0] = 32'h7FFF_FFFF;
    prod_mem[1] = 32'd1;
`ifdef AXIL_MACC_ACC_SAT_EN
    run_job("t4", 2, 1'b0, 0, 32'h7FFF_FFFF, 1'b1);
`else
    run_job("t4", 2, 1'b0, 0, 32'h8000_0000, 1'b0);
`endif
    prod_mem[0] = 32'd5;
    run_job("t4_next", 1, 1'b0, 0, 32'd5, 1'b0);

    // 5: asynchronous reset after 2 of 8 beats
    start = 1'b1;
    len   = 16'd8;
    tick();
    start = 1'b0;
    prod_valid = 1'b1;
    prod_data  = 32'd11;
    tick();
    prod_data  = 32'd22;
    tick();
    prod_valid = 1'b0;
    chk("t5_pre_busy", {63'd0, busy}, 64'd1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("t5_rst_outs", {60'd0, busy, prod_ready, acc_valid, acc_ovf}, 64'd0);
    chk("t5_rst_acc", {32'd0, acc_out}, 64'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    tick();
    prod_mem[0] = 32'hFFFF_FFFF;
    run_job("t5_after", 1, 1'b0, 0, 32'hFFFF_FFFF, 1'b0);

    // 6: random jobs against the reference model
    for (int j = 0; j < 6; j++) begin
      int n;
      n = $urandom_range(1, 64);
      for (int k = 0; k < n; k++) begin
        prod_mem[k] = (j < 3) ? 32'($signed(16'($urandom))) : $urandom;
      end
      ref_calc(n, exp_sum, exp_ovf);
      run_job($sformatf("t6_%0d", j), n, 1'b1, $urandom_range(0, 3), exp_sum, exp_ovf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
